// File: rtl/mux_n_reg_pkg.sv
// -----------------------------------------------------------------------------
// mux_pkg
// Shared constants and helpers for the N:1 registered operand selector.
//   clog2      : ceiling log2 for elaboration-time width math
//   sel_w      : select width for a given channel count (never below 1)
//   CNT_W_DEF  : default width of the accepted-transfer counter
//   sel_t      : grant encoding for the default 4-channel build
// -----------------------------------------------------------------------------
package mux_pkg;

  localparam int CNT_W_DEF  = 16;
  localparam int NUM_IN_DEF = 4;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic int sel_w(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

  localparam int SEL_W_DEF = sel_w(NUM_IN_DEF);

  typedef logic [SEL_W_DEF-1:0] sel_t;

endpackage

// File: rtl/mux_n_reg_if.sv
// -----------------------------------------------------------------------------
// mux_n_reg_if
// Bundles the operand-selector bus: NUM_IN input streams, select, one output
// stream and the status outputs.
//   slave  : the selector's view (inputs in, selected output out)
//   master : the environment's view (drives inputs, consumes output)
// -----------------------------------------------------------------------------
interface mux_n_reg_if #(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 4,
  parameter int CNT_W  = mux_pkg::CNT_W_DEF
);
  localparam int SEL_W = mux_pkg::sel_w(NUM_IN);

  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [NUM_IN-1:0]       in_valid;
  logic [NUM_IN-1:0]       in_ready;
  logic [SEL_W-1:0]        sel_in;
  logic [WIDTH-1:0]        out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic                    sel_err;
  logic [CNT_W-1:0]        xfer_cnt;

  modport slave (
    input  in_data, in_valid, sel_in, out_ready,
    output in_ready, out_data, out_valid, sel_err, xfer_cnt
  );

  modport master (
    output in_data, in_valid, sel_in, out_ready,
    input  in_ready, out_data, out_valid, sel_err, xfer_cnt
  );
endinterface

// File: rtl/mux_n_reg_skid_buf_2.sv
// -----------------------------------------------------------------------------
// skid_buf_2
// Two-entry valid/ready skid buffer with a registered in_ready. A main entry
// drives the output; a skid entry catches the one word that arrives while the
// main entry is stalled. in_ready = !skid_full, taken from a flop, so it never
// depends combinationally on out_ready.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_data/in_valid    upstream word and valid
//   in_ready            registered ready (0 during and just after reset)
//   out_data/out_valid  main entry, stable while stalled
//   out_ready           downstream ready
// -----------------------------------------------------------------------------
module skid_buf_2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [WIDTH-1:0] m_data, m_data_n, s_data, s_data_n;
  logic             m_vld, m_vld_n, s_vld, s_vld_n;
  logic             ready_q;
  logic             acc, pop;

  assign acc = in_valid && ready_q;
  assign pop = m_vld && out_ready;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch is inferred.
    m_data_n = m_data;
    m_vld_n  = m_vld;
    s_data_n = s_data;
    s_vld_n  = s_vld;
    if (s_vld) begin
      // Skid full: upstream is already stalled; drain skid into main on pop.
      if (pop) begin
        m_data_n = s_data;
        s_vld_n  = 1'b0;
      end
    end else if (acc) begin
      if (!m_vld || pop) begin
        // Main free or emptying this cycle: reload directly, no bubble.
        m_data_n = in_data;
        m_vld_n  = 1'b1;
      end else begin
        s_data_n = in_data;
        s_vld_n  = 1'b1;
      end
    end else if (pop) begin
      m_vld_n = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: data registers are reset together with the valid bits because out_data must read 0 in reset.
    if (!rst_n) begin
      m_data  <= '0;
      s_data  <= '0;
      m_vld   <= 1'b0;
      s_vld   <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      // NOTE: state is updated with non-blocking '<=' so all flops see pre-edge values.
      m_data  <= m_data_n;
      s_data  <= s_data_n;
      m_vld   <= m_vld_n;
      s_vld   <= s_vld_n;
      ready_q <= !s_vld_n;
    end
  end

  assign in_ready  = ready_q;
  assign out_data  = m_data;
  assign out_valid = m_vld;

endmodule

// File: rtl/mux_n_reg.sv
// -----------------------------------------------------------------------------
// mux_n_reg
// N:1 operand selector for the divider datapath: grant logic picks one of
// NUM_IN streams, its word goes through a 2-entry skid buffer to a registered
// output, and every accepted transfer bumps a wrapping counter.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   bus (slave)  in_data/in_valid/in_ready per channel, sel_in,
//                out_data/out_valid/out_ready, sel_err, xfer_cnt
// Build option MUX_RR_ARB_EN:
//   defined   -> round-robin grant from rr_ptr, sel_in ignored, sel_err = 0
//   undefined -> explicit grant = sel_in, sel_err flags out-of-range selects
// -----------------------------------------------------------------------------
module mux_n_reg
  import mux_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 4,
  parameter int CNT_W  = CNT_W_DEF
) (
  input logic         clk,
  input logic         rst_n,
  mux_n_reg_if.slave  bus
);

  localparam int SEL_W = sel_w(NUM_IN);

  logic [SEL_W-1:0]  grant;
  logic              grant_vld;
  logic [WIDTH-1:0]  mux_data;
  logic [NUM_IN-1:0] ready_vec;
  logic              buf_ready;
  logic              accept;
  logic [CNT_W-1:0]  cnt_q;

`ifdef MUX_RR_ARB_EN
  logic [SEL_W-1:0] rr_ptr;

  // First valid channel at or above rr_ptr, wrapping modulo NUM_IN.
  always_comb begin
    int idx;
    idx       = 0;
    grant     = '0;
    grant_vld = 1'b0;
    for (int i = 0; i < NUM_IN; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_IN) idx = idx - NUM_IN;
      if (!grant_vld && bus.in_valid[idx]) begin
        grant_vld = 1'b1;
        grant     = SEL_W'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      rr_ptr <= '0;
    else if (accept) rr_ptr <= (int'(grant) == NUM_IN - 1) ? '0 : grant + 1'b1;
  end

  assign bus.sel_err = 1'b0;
`else
  logic sel_err_q;

  assign grant     = bus.sel_in;
  assign grant_vld = int'(bus.sel_in) < NUM_IN;

  // Out-of-range select with traffic pending: flagged one cycle later, per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sel_err_q <= 1'b0;
    else        sel_err_q <= (|bus.in_valid) && !grant_vld;
  end

  assign bus.sel_err = sel_err_q;
`endif

  // Slice mux and one-hot ready; nothing is granted on an invalid select.
  always_comb begin
    mux_data  = '0;
    ready_vec = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (grant_vld && int'(grant) == i) begin
        mux_data     = bus.in_data[i*WIDTH +: WIDTH];
        ready_vec[i] = buf_ready;
      end
    end
  end

  assign bus.in_ready = ready_vec;
  assign accept       = |(bus.in_valid & ready_vec);

  skid_buf_2 #(.WIDTH(WIDTH)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (mux_data),
    .in_valid  (accept),
    .in_ready  (buf_ready),
    .out_data  (bus.out_data),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      cnt_q <= '0;
    else if (accept) cnt_q <= cnt_q + 1'b1;
  end

  assign bus.xfer_cnt = cnt_q;

endmodule

// File: tb/tb_mux_n_reg.sv
// -----------------------------------------------------------------------------
// tb_mux_n_reg
// Scoreboard bench for mux_n_reg. dut_a: 4 channels, 16-bit counter.
// dut_b: 3 channels, 4-bit counter (invalid select and counter wrap).
// Inputs are driven on the falling edge; outputs are compared just after it.
// Honours MUX_RR_ARB_EN in the grant model.
// -----------------------------------------------------------------------------
module tb_mux_n_reg;
  import mux_pkg::*;

  localparam int W  = 8;
  localparam int NA = 4;
  localparam int CA = 16;
  localparam int NB = 3;
  localparam int CB = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mux_n_reg_if #(.WIDTH(W), .NUM_IN(NA), .CNT_W(CA)) bus_a ();
  mux_n_reg_if #(.WIDTH(W), .NUM_IN(NB), .CNT_W(CB)) bus_b ();

  mux_n_reg #(.WIDTH(W), .NUM_IN(NA), .CNT_W(CA)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a.slave));
  mux_n_reg #(.WIDTH(W), .NUM_IN(NB), .CNT_W(CB)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b.slave));

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model of dut_a: scoreboard queue is the buffer occupancy.
  logic [7:0]  exp_q[$];
  bit          m_rdy;
  bit          m_err;
  logic [15:0] m_cnt;
  int          m_ptr;

  task automatic model_reset();
    exp_q.delete();
    m_rdy = 1'b0;
    m_err = 1'b0;
    m_cnt = '0;
    m_ptr = 0;
  endtask

  task automatic idle_inputs();
    bus_a.in_valid = '0; bus_a.in_data = '0; bus_a.sel_in = '0; bus_a.out_ready = 1'b1;
    bus_b.in_valid = '0; bus_b.in_data = '0; bus_b.sel_in = '0; bus_b.out_ready = 1'b1;
  endtask

  // Release reset at a falling edge; the following rising edge sets ready.
  task automatic release_reset();
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;
    @(posedge clk);
    m_rdy = 1'b1;
    m_err = 1'b0;
  endtask

  // One clock of dut_a: drive, compare against model, advance model.
  task automatic cycle_a(input logic [1:0] sel, input logic [3:0] vld,
                         input logic [31:0] data, input bit ordy);
    bit         gv;
    int         g;
    logic [3:0] rdy_vec;
    bit         acc, pop;
    @(negedge clk);
    bus_a.sel_in    = sel;
    bus_a.in_valid  = vld;
    bus_a.in_data   = data;
    bus_a.out_ready = ordy;
    gv = 1'b0;
    g  = 0;
`ifdef MUX_RR_ARB_EN
    for (int i = 0; i < NA; i++) begin
      int idx;
      idx = (m_ptr + i) % NA;
      if (!gv && vld[idx]) begin
        gv = 1'b1;
        g  = idx;
      end
    end
`else
    gv = int'(sel) < NA;
    g  = int'(sel);
`endif
    rdy_vec = (m_rdy && gv) ? 4'(1 << g) : 4'b0;
    #1;
    check("a_in_ready", 32'(bus_a.in_ready), 32'(rdy_vec));
    check("a_out_valid", 32'(bus_a.out_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) check("a_out_data", 32'(bus_a.out_data), 32'(exp_q[0]));
    check("a_xfer_cnt", 32'(bus_a.xfer_cnt), 32'(m_cnt));
    check("a_sel_err", 32'(bus_a.sel_err), 32'(m_err));
    acc = gv && m_rdy && vld[g];
    pop = (exp_q.size() != 0) && ordy;
    @(posedge clk);
    if (pop) void'(exp_q.pop_front());
    if (acc) begin
      exp_q.push_back(data[g*8 +: 8]);
      m_cnt = m_cnt + 16'd1;
      m_ptr = (g == NA - 1) ? 0 : g + 1;
    end
    m_rdy = exp_q.size() < 2;
`ifdef MUX_RR_ARB_EN
    m_err = 1'b0;
`else
    m_err = (vld != 0) && !gv;
`endif
  endtask

  initial begin
    // Reset with every channel asserting valid.
    idle_inputs();
    bus_a.in_valid = 4'hF;
    bus_a.sel_in   = 2'd2;
    bus_b.in_valid = 3'b111;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check("rst_in_ready", 32'(bus_a.in_ready), 32'h0);
    check("rst_out_valid", 32'(bus_a.out_valid), 32'h0);
    check("rst_out_data", 32'(bus_a.out_data), 32'h0);
    check("rst_xfer_cnt", 32'(bus_a.xfer_cnt), 32'h0);
    check("rst_sel_err", 32'(bus_a.sel_err), 32'h0);
    release_reset();

    // Channel 2 streams 11,22,33 while the others also assert valid.
    cycle_a(2'd2, 4'hF, 32'hA0_11_B0_C0, 1'b1);
    cycle_a(2'd2, 4'hF, 32'hA1_22_B1_C1, 1'b1);
    cycle_a(2'd2, 4'hF, 32'hA2_33_B2_C2, 1'b1);
    repeat (3) cycle_a(2'd2, 4'h0, 32'h0, 1'b1);

    // Backpressure: three stalled cycles mid-stream, then drain.
    for (int k = 0; k < 8; k++)
      cycle_a(2'd1, 4'b0010, {16'h0, 8'h40 + 8'(k), 8'h0}, !(k >= 2 && k <= 4));
    repeat (4) cycle_a(2'd1, 4'h0, 32'h0, 1'b1);

    // All channels valid, then only ch1/ch3 valid (round-robin pattern).
    for (int k = 0; k < 6; k++)
      cycle_a(2'(k), 4'hF, {8'h30 + 8'(k), 8'h20 + 8'(k), 8'h10 + 8'(k), 8'h00 + 8'(k)}, 1'b1);
    for (int k = 0; k < 5; k++)
      cycle_a(2'd3, 4'b1010, {8'h70 + 8'(k), 8'h0, 8'h50 + 8'(k), 8'h0}, 1'b1);
    repeat (3) cycle_a(2'd0, 4'h0, 32'h0, 1'b1);

    // Select, valids and downstream ready change every cycle.
    for (int k = 0; k < 60; k++)
      cycle_a(2'($urandom_range(0, 3)), 4'($urandom), $urandom, 1'($urandom));
    repeat (4) cycle_a(2'd0, 4'h0, 32'h0, 1'b1);

    // Reset mid-burst with both entries full: output drops at once.
    for (int k = 0; k < 4; k++)
      cycle_a(2'd0, 4'b0001, {24'h0, 8'h90 + 8'(k)}, 1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(bus_a.out_valid), 32'h0);
    check("midrst_in_ready", 32'(bus_a.in_ready), 32'h0);
    check("midrst_xfer_cnt", 32'(bus_a.xfer_cnt), 32'h0);
    model_reset();
    release_reset();
    repeat (3) cycle_a(2'd0, 4'h0, 32'h0, 1'b1);

`ifndef MUX_RR_ARB_EN
    // Out-of-range select on the 3-channel instance.
    @(negedge clk);
    bus_b.sel_in   = 2'd3;
    bus_b.in_valid = 3'b111;
    bus_b.in_data  = 24'hCC_BB_AA;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      check("b_bad_ready", 32'(bus_b.in_ready), 32'h0);
      check("b_sel_err", 32'(bus_b.sel_err), 32'h1);
      check("b_bad_cnt", 32'(bus_b.xfer_cnt), 32'h0);
      check("b_bad_out_valid", 32'(bus_b.out_valid), 32'h0);
    end
    bus_b.in_valid = 3'b000;
    @(negedge clk);
    #1;
    check("b_sel_err_clear", 32'(bus_b.sel_err), 32'h0);
`endif

    // Counter wrap on the 4-bit counter: 17 back-to-back accepts on ch0.
    @(negedge clk);
    bus_b.sel_in    = 2'd0;
    bus_b.in_valid  = 3'b001;
    bus_b.out_ready = 1'b1;
    bus_b.in_data   = 24'd1;
    for (int k = 2; k <= 18; k++) begin
      @(negedge clk);
      #1;
      check("b_wrap_ready", 32'(bus_b.in_ready), 32'h1);
      check("b_wrap_cnt", 32'(bus_b.xfer_cnt), 32'((k - 1) % 16));
      check("b_wrap_data", 32'(bus_b.out_data), 32'(k - 1));
      check("b_wrap_valid", 32'(bus_b.out_valid), 32'h1);
      if (k == 18) bus_b.in_valid = 3'b000;
      else         bus_b.in_data  = 24'(k);
    end
    @(negedge clk);
    #1;
    check("b_wrap_final_cnt", 32'(bus_b.xfer_cnt), 32'h1);
    check("b_drained", 32'(bus_b.out_valid), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
